// File: rtl/adc_seq_pkg.sv
// Shared types, widths and helpers for the MAX10 ADC command sequencer.
package adc_seq_pkg;

  localparam int unsigned ADC_DATA_W = 12;
  localparam int unsigned ADC_CHAN_W = 5;
  localparam int unsigned MAX_SLOTS  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } seq_state_e;

  // Pick the 5-bit channel for a slot out of the packed slot table.
  function automatic logic [ADC_CHAN_W-1:0] slot_channel(
    input logic [MAX_SLOTS*ADC_CHAN_W-1:0] chans,
    input logic [1:0]                      slot
  );
    return chans[int'(slot)*ADC_CHAN_W +: ADC_CHAN_W];
  endfunction

endpackage

// File: rtl/adc_slot_accumulator.sv
// Per-slot running sum of 2^AVG_LOG2 conversions; emits the truncated mean.
module adc_slot_accumulator
  import adc_seq_pkg::*;
#(
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  add_i,
  input  logic [ADC_DATA_W-1:0] data_i,
  output logic                  done_o,
  output logic [ADC_DATA_W-1:0] result_o
);

  localparam int unsigned AccW = ADC_DATA_W + AVG_LOG2;
  localparam int unsigned CntW = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam logic [CntW-1:0] CntLast = CntW'((1 << AVG_LOG2) - 1);

  logic [AccW-1:0] acc_q, acc_d, sum;
  logic [CntW-1:0] cnt_q, cnt_d;

  // The sum includes the incoming sample so the mean is ready in the add cycle.
  assign sum      = acc_q + AccW'(data_i);
  assign done_o   = add_i && (cnt_q == CntLast);
  assign result_o = sum[AccW-1:AVG_LOG2];

  // Next-state: accumulate, or restart once the block of conversions is complete.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (add_i) begin
      if (done_o) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // Accumulator and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/adc_sequencer.sv
// Round-robin command scheduler for the MAX10 ADC with per-slot averaging,
// a single-entry sample output register and lost/misrouted response detection.
module adc_sequencer
  import adc_seq_pkg::*;
#(
  parameter int unsigned NUM_SLOTS      = 2,
  parameter logic [19:0] SLOT_CHANNELS  = 20'h00021,
  parameter int unsigned AVG_LOG2       = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable_in,
  input  logic                  clear_in,
  output logic                  command_valid_out,
  output logic [ADC_CHAN_W-1:0] command_channel_out,
  output logic                  command_startofpacket_out,
  output logic                  command_endofpacket_out,
  input  logic                  command_ready_in,
  input  logic                  response_valid_in,
  input  logic [ADC_CHAN_W-1:0] response_channel_in,
  input  logic [ADC_DATA_W-1:0] response_data_in,
  output logic [ADC_DATA_W-1:0] sample_out,
  output logic [1:0]            sample_slot_out,
  output logic                  sample_stb_out,
  input  logic                  sample_ack_in,
  output logic                  overrun_out,
  output logic [7:0]            error_count_out,
  output logic                  busy_out
);

  localparam int unsigned TimerW   = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0]  LastSlot = 2'(NUM_SLOTS - 1);

  seq_state_e              state_q, state_d;
  logic [1:0]              slot_q, slot_d;
  logic [TimerW-1:0]       timer_q, timer_d;
  logic [ADC_DATA_W-1:0]   sample_q, sample_d;
  logic [1:0]              sslot_q, sslot_d;
  logic                    stb_q, stb_d;
  logic                    ovr_q, ovr_d;
  logic [7:0]              err_q, err_d;

  logic [ADC_CHAN_W-1:0]   cur_chan;
  logic                    cmd_fire, resp_ok, resp_bad, timed_out, wait_exit, in_wait;
  logic                    new_res;
  logic [MAX_SLOTS-1:0]    slot_done;
  logic [ADC_DATA_W-1:0]   slot_result [MAX_SLOTS];

  assign cur_chan  = slot_channel(SLOT_CHANNELS, slot_q);
  assign in_wait   = (state_q == StWait);
  assign cmd_fire  = command_valid_out && command_ready_in;
  assign resp_ok   = in_wait && response_valid_in && (response_channel_in == cur_chan);
  assign resp_bad  = in_wait && response_valid_in && (response_channel_in != cur_chan);
  // A response in the final timer cycle wins over the timeout.
  assign timed_out = in_wait && !response_valid_in && (timer_q == TimerW'(TIMEOUT_CYCLES));
  assign wait_exit = resp_ok || resp_bad || timed_out;

  for (genvar s = 0; s < MAX_SLOTS; s++) begin : g_slot
    if (s < NUM_SLOTS) begin : g_acc
      adc_slot_accumulator #(
        .AVG_LOG2 (AVG_LOG2)
      ) u_acc (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (state_q == StIdle),
        .add_i    (resp_ok && (slot_q == 2'(s))),
        .data_i   (response_data_in),
        .done_o   (slot_done[s]),
        .result_o (slot_result[s])
      );
    end else begin : g_unused
      assign slot_done[s]   = 1'b0;
      assign slot_result[s] = '0;
    end
  end

  assign new_res = slot_done[slot_q];

  // Controller: next state, slot rotation and response timer.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    timer_d = timer_q;
    unique case (state_q)
      StIdle: begin
        slot_d  = '0;
        timer_d = '0;
        if (enable_in) state_d = StIssue;
      end
      StIssue: begin
        // An accepted command is always followed through, even if enable just fell.
        if (cmd_fire) begin
          state_d = StWait;
          timer_d = '0;
        end else if (!enable_in) begin
          state_d = StIdle;
          slot_d  = '0;
        end
      end
      StWait: begin
        if (wait_exit) begin
          if (enable_in) begin
            state_d = StIssue;
            slot_d  = (slot_q == LastSlot) ? 2'd0 : slot_q + 2'd1;
          end else begin
            state_d = StIdle;
            slot_d  = '0;
          end
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output register, sticky overrun and saturating error counter.
  always_comb begin
    sample_d = sample_q;
    sslot_d  = sslot_q;
    stb_d    = stb_q;
    ovr_d    = ovr_q;
    err_d    = err_q;
    if (new_res) begin
      sample_d = slot_result[slot_q];
      sslot_d  = slot_q;
      stb_d    = 1'b1;
      if (stb_q && !sample_ack_in) ovr_d = 1'b1;
    end else if (stb_q && sample_ack_in) begin
      stb_d = 1'b0;
    end
    if ((resp_bad || timed_out) && (err_q != 8'hFF)) err_d = err_q + 8'd1;
    if (clear_in) begin
      ovr_d = 1'b0;
      err_d = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      slot_q   <= '0;
      timer_q  <= '0;
      sample_q <= '0;
      sslot_q  <= '0;
      stb_q    <= 1'b0;
      ovr_q    <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      timer_q  <= timer_d;
      sample_q <= sample_d;
      sslot_q  <= sslot_d;
      stb_q    <= stb_d;
      ovr_q    <= ovr_d;
      err_q    <= err_d;
    end
  end

  assign command_valid_out         = (state_q == StIssue);
  assign command_channel_out       = command_valid_out ? cur_chan : '0;
  assign command_startofpacket_out = command_valid_out;
  assign command_endofpacket_out   = command_valid_out;
  assign busy_out                  = (state_q != StIdle);
  assign sample_out                = sample_q;
  assign sample_slot_out           = sslot_q;
  assign sample_stb_out            = stb_q;
  assign overrun_out               = ovr_q;
  assign error_count_out           = err_q;

endmodule

// File: tb/tb_adc_sequencer.sv
// Self-checking bench: two slots (ch 1, ch 8), 4-sample averaging, 15-cycle timeout.
module tb_adc_sequencer;

  logic        clk = 1'b0;
  logic        rst, enable_in, clear_in, command_ready_in, sample_ack_in;
  logic        response_valid_in;
  logic [4:0]  response_channel_in;
  logic [11:0] response_data_in;
  logic        command_valid_out, command_startofpacket_out, command_endofpacket_out;
  logic [4:0]  command_channel_out;
  logic [11:0] sample_out;
  logic [1:0]  sample_slot_out;
  logic        sample_stb_out, overrun_out, busy_out;
  logic [7:0]  error_count_out;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state: conversion-level view of the sequencer.
  int          chan_tab [2] = '{1, 8};
  int          m_slot, m_err;
  int unsigned m_sum [2];
  int          m_cnt [2];
  bit          m_stb, m_ovr;
  int          m_sample, m_sslot;
  bit          pend_res;
  int          pend_val, pend_slot;

  adc_sequencer #(
    .NUM_SLOTS      (2),
    .SLOT_CHANNELS  (20'h00101),
    .AVG_LOG2       (2),
    .TIMEOUT_CYCLES (15)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .enable_in                 (enable_in),
    .clear_in                  (clear_in),
    .command_valid_out         (command_valid_out),
    .command_channel_out       (command_channel_out),
    .command_startofpacket_out (command_startofpacket_out),
    .command_endofpacket_out   (command_endofpacket_out),
    .command_ready_in          (command_ready_in),
    .response_valid_in         (response_valid_in),
    .response_channel_in       (response_channel_in),
    .response_data_in          (response_data_in),
    .sample_out                (sample_out),
    .sample_slot_out           (sample_slot_out),
    .sample_stb_out            (sample_stb_out),
    .sample_ack_in             (sample_ack_in),
    .overrun_out               (overrun_out),
    .error_count_out           (error_count_out),
    .busy_out                  (busy_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_idle();
    m_slot = 0;
    m_sum  = '{0, 0};
    m_cnt  = '{0, 0};
  endtask

  // One clock; the output-register model follows the stb/ack rules at the same edge.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      m_stb = 0; m_ovr = 0; m_err = 0; m_sample = 0; m_sslot = 0;
      model_idle();
    end else begin
      if (pend_res) begin
        if (m_stb && !sample_ack_in) m_ovr = 1;
        m_stb = 1; m_sample = pend_val; m_sslot = pend_slot;
      end else if (m_stb && sample_ack_in) begin
        m_stb = 0;
      end
      if (clear_in) begin m_ovr = 0; m_err = 0; end
    end
    pend_res = 0;
    #1;
  endtask

  task automatic wait_cmd(output bit seen);
    int n = 0;
    while (!command_valid_out && n < 50) begin step(); n++; end
    seen = command_valid_out;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_stb"}, int'(sample_stb_out), int'(m_stb));
    if (m_stb) begin
      chk({tag, "_sample"}, int'(sample_out), m_sample);
      chk({tag, "_sslot"}, int'(sample_slot_out), m_sslot);
    end
    chk({tag, "_ovr"}, int'(overrun_out), int'(m_ovr));
    chk({tag, "_err"}, int'(error_count_out), m_err);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, int'(command_valid_out), 0);
    chk({tag, "_chan"}, int'(command_channel_out), 0);
    chk({tag, "_sop"}, int'(command_startofpacket_out), 0);
    chk({tag, "_eop"}, int'(command_endofpacket_out), 0);
    chk({tag, "_sample"}, int'(sample_out), 0);
    chk({tag, "_sslot"}, int'(sample_slot_out), 0);
    chk({tag, "_stb"}, int'(sample_stb_out), 0);
    chk({tag, "_ovr"}, int'(overrun_out), 0);
    chk({tag, "_err"}, int'(error_count_out), 0);
    chk({tag, "_busy"}, int'(busy_out), 0);
  endtask

  // kind: 0 matching response, 1 wrong channel, 2 no response (timeout).
  // data < 0 picks random data; ack_resp >= 0 sets sample_ack_in for the response cycle.
  task automatic convert(input int kind, input int data, input int ack_resp, input bit drop_en);
    bit          seen;
    int          n;
    logic [11:0] dv;
    wait_cmd(seen);
    chk("cmd_valid", int'(seen), 1);
    chk("cmd_chan", int'(command_channel_out), chan_tab[m_slot]);
    chk("cmd_sop_eop", int'({command_startofpacket_out, command_endofpacket_out}), 3);
    command_ready_in = 1'b1;
    step();
    command_ready_in = 1'b0;
    if (drop_en) enable_in = 1'b0;
    chk("wait_valid", int'(command_valid_out), 0);
    chk("wait_busy", int'(busy_out), 1);
    chk("wait_stb", int'(sample_stb_out), int'(m_stb));
    if (kind == 2) begin
      n = 1;
      while (!command_valid_out && n < 40) begin step(); n++; end
      chk("timeout_cycles", n, 17);
      if (m_err < 255) m_err++;
    end else begin
      dv = (data < 0) ? 12'($urandom_range(0, 4095)) : 12'(data);
      if (ack_resp >= 0) sample_ack_in = ack_resp[0];
      response_valid_in   = 1'b1;
      response_channel_in = (kind == 0) ? 5'(chan_tab[m_slot]) : 5'd3;
      response_data_in    = dv;
      if (kind == 0) begin
        m_sum[m_slot] += dv;
        m_cnt[m_slot]++;
        if (m_cnt[m_slot] == 4) begin
          pend_res  = 1;
          pend_val  = int'(m_sum[m_slot] / 4);
          pend_slot = m_slot;
          m_sum[m_slot] = 0;
          m_cnt[m_slot] = 0;
        end
      end
      step();
      response_valid_in = 1'b0;
      if (kind == 1 && m_err < 255) m_err++;
    end
    if (enable_in) m_slot = (m_slot + 1) % 2;
    else model_idle();
    chk("post_busy", int'(busy_out), int'(enable_in));
    check_outputs("post");
  endtask

  initial begin
    bit seen;
    int ch;
    rst = 1'b1; enable_in = 1'b0; clear_in = 1'b0; command_ready_in = 1'b0;
    sample_ack_in = 1'b0; response_valid_in = 1'b0; response_channel_in = '0;
    response_data_in = '0; pend_res = 0;
    step(); step();
    rst = 1'b0;
    check_all_zero("reset");

    // Basic averaging: slot 0 gets 100..103, slot 1 random, ack held high.
    enable_in = 1'b1; sample_ack_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      convert(0, 100 + i, -1, 0);
      if (i == 3) begin
        chk("basic_avg", int'(sample_out), 101);
        chk("basic_slot", int'(sample_slot_out), 0);
        chk("basic_stb", int'(sample_stb_out), 1);
      end
      convert(0, -1, -1, 0);
      if (i == 3) chk("basic_stb_one_cycle_slot1", int'(sample_slot_out), 1);
    end
    chk("basic_err", int'(error_count_out), 0);

    // Channel mismatch then timeout.
    convert(1, -1, -1, 0);
    chk("mismatch_err", int'(error_count_out), 1);
    convert(2, -1, -1, 0);
    chk("timeout_err", int'(error_count_out), 2);

    // Random mix of outcomes and consumer backpressure.
    for (int i = 0; i < 40; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      sample_ack_in = 1'($urandom_range(0, 1));
      convert((r < 8) ? 0 : ((r == 8) ? 1 : 2), -1, -1, 0);
    end

    // Drain to IDLE and clear counters.
    enable_in = 1'b0; clear_in = 1'b1; sample_ack_in = 1'b1;
    step(); step();
    clear_in = 1'b0;
    model_idle();
    chk("drain_busy", int'(busy_out), 0);
    check_outputs("cleared");

    // Backpressure: second unacked sample overruns; clear_in drops the flag.
    enable_in = 1'b1; sample_ack_in = 1'b0;
    for (int i = 0; i < 8; i++) convert(0, -1, -1, 0);
    chk("overrun_set", int'(overrun_out), 1);
    chk("overrun_slot", int'(sample_slot_out), 1);
    clear_in = 1'b1; step(); clear_in = 1'b0;
    chk("overrun_cleared", int'(overrun_out), 0);
    sample_ack_in = 1'b1; step(); sample_ack_in = 1'b0;
    chk("ack_drops_stb", int'(sample_stb_out), 0);
    for (int i = 0; i < 7; i++) convert(0, -1, -1, 0);
    convert(0, -1, 1, 0);
    chk("ack_with_new_stb", int'(sample_stb_out), 1);
    chk("ack_with_new_no_ovr", int'(overrun_out), 0);

    // Error counter saturation, then clear.
    sample_ack_in = 1'b1;
    for (int i = 0; i < 300; i++) convert(2, -1, -1, 0);
    chk("err_saturated", int'(error_count_out), 255);
    clear_in = 1'b1; step(); clear_in = 1'b0;
    chk("err_cleared", int'(error_count_out), 0);

    // Ready stall: command held stable, enable drop abandons it.
    wait_cmd(seen);
    ch = chan_tab[m_slot];
    for (int i = 0; i < 20; i++) begin
      step();
      chk("stall_valid", int'(command_valid_out), 1);
      chk("stall_chan", int'(command_channel_out), ch);
    end
    enable_in = 1'b0;
    step();
    model_idle();
    chk("stall_abandon_busy", int'(busy_out), 0);
    chk("stall_abandon_valid", int'(command_valid_out), 0);

    // Enable dropped during WAIT: conversion completes, then IDLE.
    enable_in = 1'b1;
    convert(0, -1, -1, 1);
    chk("drop_in_wait_busy", int'(busy_out), 0);

    // Reset mid-WAIT, late response ignored, fresh averaging afterwards.
    enable_in = 1'b1;
    wait_cmd(seen);
    command_ready_in = 1'b1; step(); command_ready_in = 1'b0;
    chk("pre_reset_busy", int'(busy_out), 1);
    enable_in = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("midwait_reset");
    response_valid_in = 1'b1; response_channel_in = 5'd1; response_data_in = 12'hFFF;
    step();
    response_valid_in = 1'b0;
    chk("late_resp_stb", int'(sample_stb_out), 0);
    chk("late_resp_busy", int'(busy_out), 0);
    chk("late_resp_err", int'(error_count_out), 0);
    enable_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      convert(0, 200 + i, -1, 0);
      if (i == 3) chk("restart_avg", int'(sample_out), 201);
      convert(0, -1, -1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
